// File: rtl/bram_pipe_if.sv
// Request/response bundle for bram_pipe: the master issues writes and reads,
// the slave (the memory) returns read data with a valid flag.
interface bram_pipe_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 9
);
    logic               i_wr_en;
    logic [ADDR_SZ-1:0] i_waddr;
    logic [DATA_SZ-1:0] i_wdata;
    logic [DATA_SZ-1:0] i_wmask;
    logic               i_rd_en;
    logic [ADDR_SZ-1:0] i_raddr;
    logic [DATA_SZ-1:0] o_rdata;
    logic               o_rvalid;

    modport master (
        output i_wr_en, i_waddr, i_wdata, i_wmask, i_rd_en, i_raddr,
        input  o_rdata, o_rvalid
    );

    modport slave (
        input  i_wr_en, i_waddr, i_wdata, i_wmask, i_rd_en, i_raddr,
        output o_rdata, o_rvalid
    );
endinterface

// File: rtl/bram_pipe.sv
// Single-clock block RAM with bit-masked writes and a fully pipelined read port
// (latency 1 or 2), with selectable read-during-write behaviour.
module bram_pipe #(
    parameter int DATA_SZ  = 16,
    parameter int ADDR_SZ  = 9,
    parameter int MEM_MAX  = (1 << ADDR_SZ),
    parameter int READ_LAT = 1,
    parameter int BYPASS   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    bram_pipe_if.slave bus
);
    localparam int               IDX_SZ  = (MEM_MAX > 1) ? $clog2(MEM_MAX) : 1;
    localparam logic [ADDR_SZ:0] MEM_LIM = (ADDR_SZ + 1)'(MEM_MAX);

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
            $error("bram_pipe: READ_LAT must be 1 or 2");
        end
        if (MEM_MAX < 1 || MEM_MAX > (1 << ADDR_SZ)) begin : g_bad_mem
            $error("bram_pipe: MEM_MAX must be in 1..(1<<ADDR_SZ)");
        end
        if (DATA_SZ < 1 || DATA_SZ > 32 || ADDR_SZ < 1) begin : g_bad_width
            $error("bram_pipe: DATA_SZ must be 1..32 and ADDR_SZ at least 1");
        end
    endgenerate

    logic [DATA_SZ-1:0] mem [MEM_MAX];

    logic               wr_hit;
    logic               rd_hit;
    logic [IDX_SZ-1:0]  w_idx;
    logic [IDX_SZ-1:0]  r_idx;

    logic [DATA_SZ-1:0] ram_q;
    logic               valid1;
    logic               hit1;
    logic               coll1;
    logic [DATA_SZ-1:0] wdata1;
    logic [DATA_SZ-1:0] wmask1;
    logic [DATA_SZ-1:0] data1;

    assign wr_hit = bus.i_wr_en && ({1'b0, bus.i_waddr} < MEM_LIM);
    assign rd_hit = ({1'b0, bus.i_raddr} < MEM_LIM);
    assign w_idx  = bus.i_waddr[IDX_SZ-1:0];
    assign r_idx  = rd_hit ? bus.i_raddr[IDX_SZ-1:0] : '0;

    // Array port kept free of reset so it maps onto a block RAM primitive.
    always_ff @(posedge i_clk) begin
        if (wr_hit) begin
            mem[w_idx] <= (mem[w_idx] & ~bus.i_wmask) | (bus.i_wdata & bus.i_wmask);
        end
    end

    always_ff @(posedge i_clk) begin
        if (bus.i_rd_en) begin
            ram_q <= mem[r_idx];
        end
    end

    // Side-band of the first read stage; the collision flag plus the captured
    // write word let the output merge in a same-edge write when bypassing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid1 <= 1'b0;
            hit1   <= 1'b0;
            coll1  <= 1'b0;
            wdata1 <= '0;
            wmask1 <= '0;
        end else begin
            valid1 <= bus.i_rd_en;
            hit1   <= bus.i_rd_en && rd_hit;
            coll1  <= (BYPASS != 0) && bus.i_rd_en && wr_hit
                      && (bus.i_raddr == bus.i_waddr);
            if (bus.i_wr_en) begin
                wdata1 <= bus.i_wdata;
                wmask1 <= bus.i_wmask;
            end
        end
    end

    always_comb begin
        data1 = '0;
        if (hit1) begin
            data1 = coll1 ? ((ram_q & ~wmask1) | (wdata1 & wmask1)) : ram_q;
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_SZ-1:0] data2;
            logic               valid2;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data2  <= '0;
                    valid2 <= 1'b0;
                end else begin
                    data2  <= data1;
                    valid2 <= valid1;
                end
            end

            assign bus.o_rdata  = data2;
            assign bus.o_rvalid = valid2;
        end else begin : g_lat1
            assign bus.o_rdata  = data1;
            assign bus.o_rvalid = valid1;
        end
    endgenerate
endmodule

// File: tb/tb_bram_pipe.sv
// Drives two bram_pipe instances (default build, and MEM_MAX=300 / READ_LAT=2 /
// BYPASS=0) with identical traffic and checks each against a memory model.
module tb_bram_pipe;
    typedef struct packed {
        logic        v;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic        we;
        logic [8:0]  wa;
        logic [15:0] wd;
        logic [15:0] wm;
        logic        re;
        logic [8:0]  ra;
        logic        av;
        logic [15:0] ad;
        logic        bv;
        logic [15:0] bd;
    } vec_t;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    logic        wr_en = 1'b0;
    logic [8:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] wmask = '0;
    logic        rd_en = 1'b0;
    logic [8:0]  raddr = '0;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem_a [512];
    logic [15:0] mem_b [300];
    exp_t        qa [$];
    exp_t        qb [$];
    vec_t        vecs [$];

    always #5 i_clk = ~i_clk;

    bram_pipe_if #(.DATA_SZ(16), .ADDR_SZ(9)) bus_a ();
    bram_pipe_if #(.DATA_SZ(16), .ADDR_SZ(9)) bus_b ();

    assign bus_a.i_wr_en = wr_en;
    assign bus_a.i_waddr = waddr;
    assign bus_a.i_wdata = wdata;
    assign bus_a.i_wmask = wmask;
    assign bus_a.i_rd_en = rd_en;
    assign bus_a.i_raddr = raddr;
    assign bus_b.i_wr_en = wr_en;
    assign bus_b.i_waddr = waddr;
    assign bus_b.i_wdata = wdata;
    assign bus_b.i_wmask = wmask;
    assign bus_b.i_rd_en = rd_en;
    assign bus_b.i_raddr = raddr;

    bram_pipe #(
        .DATA_SZ(16), .ADDR_SZ(9), .MEM_MAX(512), .READ_LAT(1), .BYPASS(1)
    ) dut_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_a)
    );

    bram_pipe #(
        .DATA_SZ(16), .ADDR_SZ(9), .MEM_MAX(300), .READ_LAT(2), .BYPASS(0)
    ) dut_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus_b)
    );

    task automatic check_output(input string name, input logic act_v, input logic [15:0] act_d,
                                input logic exp_v, input logic [15:0] exp_d);
        total++;
        if (act_v !== exp_v || act_d !== exp_d) begin
            bad++;
            $display("[TB] FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                     name, act_v, act_d, exp_v, exp_d);
        end
    endtask

    // Latency-1 build has an empty delay line; latency-2 build starts with one idle slot.
    task automatic clear_pipes();
        qa.delete();
        qb.delete();
        qb.push_back('{1'b0, 16'h0000});
    endtask

    task automatic apply_stimulus(input logic we, input logic [8:0] wa, input logic [15:0] wd,
                                  input logic [15:0] wm, input logic re, input logic [8:0] ra);
        exp_t        ea;
        exp_t        eb;
        logic [15:0] w;
        wr_en = we;
        waddr = wa;
        wdata = wd;
        wmask = wm;
        rd_en = re;
        raddr = ra;
        ea = '{1'b0, 16'h0000};
        eb = '{1'b0, 16'h0000};
        if (re) begin
            w = mem_a[ra];
            if (we && wa == ra) w = (w & ~wm) | (wd & wm);
            ea = '{1'b1, w};
            eb = '{1'b1, (int'(ra) < 300) ? mem_b[ra] : 16'h0000};
        end
        qa.push_back(ea);
        qb.push_back(eb);
        if (we) begin
            mem_a[wa] = (mem_a[wa] & ~wm) | (wd & wm);
            if (int'(wa) < 300) mem_b[wa] = (mem_b[wa] & ~wm) | (wd & wm);
        end
        @(posedge i_clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        check_output("mdl_a", bus_a.o_rvalid, bus_a.o_rdata, ea.v, ea.d);
        check_output("mdl_b", bus_b.o_rvalid, bus_b.o_rdata, eb.v, eb.d);
    endtask

    function automatic logic [8:0] pick_addr();
        case ($urandom_range(0, 2))
            0:       return 9'($urandom_range(0, 511));
            1:       return 9'($urandom_range(296, 303));
            default: return 9'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want $finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [8:0] wa;
        // Columns: we waddr wdata wmask re raddr | A valid/data | B valid/data
        vecs.push_back('{1'b1, 9'd5,   16'h1234, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd5,   1'b1, 16'h1234, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h1234});
        vecs.push_back('{1'b1, 9'd7,   16'hFFFF, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd7,   16'h0000, 16'h00F0, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd7,   1'b1, 16'hFF0F, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd3,   16'hAAAA, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'hFF0F});
        vecs.push_back('{1'b1, 9'd3,   16'h5555, 16'hFFFF, 1'b1, 9'd3,   1'b1, 16'h5555, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd3,   1'b1, 16'h5555, 1'b1, 16'hAAAA});
        vecs.push_back('{1'b1, 9'd310, 16'hBEEF, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h5555});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd310, 1'b1, 16'hBEEF, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd299, 16'h4242, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd299, 1'b1, 16'h4242, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd0,   16'h0010, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h4242});
        vecs.push_back('{1'b1, 9'd1,   16'h0011, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd2,   16'h0012, 16'hFFFF, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd0,   1'b1, 16'h0010, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd1,   1'b1, 16'h0011, 1'b1, 16'h0010});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd2,   1'b1, 16'h0012, 1'b1, 16'h0011});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h0012});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 9'd5,   16'hFFFF, 16'h0000, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b1, 9'd5,   1'b1, 16'h1234, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 9'd0,   16'h0000, 16'h0000, 1'b0, 9'd0,   1'b0, 16'h0000, 1'b1, 16'h1234});

        #1;
        check_output("reset_a", bus_a.o_rvalid, bus_a.o_rdata, 1'b0, 16'h0000);
        check_output("reset_b", bus_b.o_rvalid, bus_b.o_rdata, 1'b0, 16'h0000);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        clear_pipes();

        // Give every word a known value so the model can predict any read.
        for (int a = 0; a < 512; a++) begin
            apply_stimulus(1'b1, 9'(a), 16'($urandom), 16'hFFFF, 1'b0, 9'd0);
        end
        apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b0, 9'd0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wm, vecs[i].re, vecs[i].ra);
            check_output($sformatf("tbl%0d_a", i), bus_a.o_rvalid, bus_a.o_rdata, vecs[i].av, vecs[i].ad);
            check_output($sformatf("tbl%0d_b", i), bus_b.o_rvalid, bus_b.o_rdata, vecs[i].bv, vecs[i].bd);
        end

        // Reset asserted between edges while reads are still in flight.
        apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b1, 9'd1);
        apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b1, 9'd2);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #3;
        i_rst_n = 1'b0;
        #1;
        check_output("rst_mid_a", bus_a.o_rvalid, bus_a.o_rdata, 1'b0, 16'h0000);
        check_output("rst_mid_b", bus_b.o_rvalid, bus_b.o_rdata, 1'b0, 16'h0000);
        repeat (2) @(posedge i_clk);
        #1;
        check_output("rst_hold_b", bus_b.o_rvalid, bus_b.o_rdata, 1'b0, 16'h0000);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        clear_pipes();
        repeat (3) apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b0, 9'd0);
        apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b1, 9'd1);
        check_output("rst_mem1_a", bus_a.o_rvalid, bus_a.o_rdata, 1'b1, 16'h0011);
        apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b0, 9'd0);
        check_output("rst_mem1_b", bus_b.o_rvalid, bus_b.o_rdata, 1'b1, 16'h0011);

        // Random traffic biased toward collisions and the MEM_MAX boundary.
        for (int n = 0; n < 400; n++) begin
            wa = pick_addr();
            apply_stimulus(1'($urandom_range(0, 1)), wa, 16'($urandom), 16'($urandom),
                           1'($urandom_range(0, 3) != 0),
                           ($urandom_range(0, 2) == 0) ? wa : pick_addr());
        end
        repeat (2) apply_stimulus(1'b0, 9'd0, 16'h0000, 16'h0000, 1'b0, 9'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
